// File: rtl/pixel_rx_pkg.sv
// Shared types and widths for the ray-tracer pixel stream receiver.
package pixel_rx_pkg;
  localparam int DIM_W = 13;
  localparam int PIX_W = 24;

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;
endpackage

// File: rtl/pixel_out_stage.sv
// One-entry valid/ready output register; upstream ready passes through when
// the held entry is being drained in the same cycle.
module pixel_out_stage #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              ready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  assign ready = !wr_valid || wr_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (in_valid && ready) begin
      wr_valid <= 1'b1;
      wr_addr  <= in_addr;
      wr_data  <= in_data;
    end else if (wr_ready) begin
      wr_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pixel_stream_receiver.sv
// Pixel stream sink: checks sof/last_x framing against the configured image
// size and turns each accepted pixel into a linear frame-buffer write.
module pixel_stream_receiver
  import pixel_rx_pkg::*;
#(
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIM_W-1:0]  image_width,
  input  logic [DIM_W-1:0]  image_height,
  input  logic              valid_in,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  input  logic              sof,
  input  logic              last_x,
  output logic              ready_out,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              sof_err,
  output logic              eol_err,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  drop_count
);
  state_t             state, state_d;
  logic [DIM_W-1:0]   width, height, x, y;
  logic [ADDR_W-1:0]  addr, line_base, in_addr;
  logic               xfer, dims_ok, x_last, y_last, single;
  logic               load, start, advance, eol, drop, set_sof, set_eol, frame_end;
  pixel_t             pix;

  assign pix     = {r, g, b};
  assign xfer    = valid_in && ready_out;
  assign dims_ok = (image_width != '0) && (image_height != '0);
  assign single  = (image_width == DIM_W'(1)) && (image_height == DIM_W'(1));
  assign x_last  = (x == width - DIM_W'(1));
  assign y_last  = (y == height - DIM_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    start     = 1'b0;
    advance   = 1'b0;
    eol       = 1'b0;
    drop      = 1'b0;
    set_sof   = 1'b0;
    set_eol   = 1'b0;
    frame_end = 1'b0;
    in_addr   = addr;
    if (xfer) begin
      // A mid-frame sof is only an error when it lands off pixel (0,0).
      if (sof) set_sof = (state == ACTIVE) && ((x != '0) || (y != '0));
      if (sof && dims_ok) begin
        start   = 1'b1;
        load    = 1'b1;
        in_addr = '0;
        if (single) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d   = ACTIVE;
        end
      end else if (sof || state == IDLE) begin
        drop    = 1'b1;
        state_d = IDLE;
      end else begin
        load    = 1'b1;
        advance = 1'b1;
        eol     = last_x || x_last;
        set_eol = last_x != x_last;
        if (eol && y_last) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      width       <= '0;
      height      <= '0;
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      line_base   <= '0;
      frame_done  <= 1'b0;
      sof_err     <= 1'b0;
      eol_err     <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) frame_count <= frame_count + CNT_W'(1);
      if (drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      if (set_sof) sof_err <= 1'b1;
      if (set_eol) eol_err <= 1'b1;
      if (start) begin
        width  <= image_width;
        height <= image_height;
        addr   <= ADDR_W'(1);
        if (image_width == DIM_W'(1)) begin
          x         <= '0;
          y         <= DIM_W'(1);
          line_base <= ADDR_W'(1);
        end else begin
          x         <= DIM_W'(1);
          y         <= '0;
          line_base <= '0;
        end
      end else if (advance) begin
        // line_base realigns the address even when last_x comes early.
        if (eol) begin
          x         <= '0;
          y         <= y + DIM_W'(1);
          addr      <= line_base + ADDR_W'(width);
          line_base <= line_base + ADDR_W'(width);
        end else begin
          x    <= x + DIM_W'(1);
          addr <= addr + ADDR_W'(1);
        end
      end
    end
  end

  pixel_out_stage #(.ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_out (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (load),
    .in_addr  (in_addr),
    .in_data  (pix),
    .ready    (ready_out),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );
endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Self-checking bench: per-cycle compare against a pixel-position model plus
// directed framing scenarios and randomized frames.
`timescale 1ns/1ps
module tb_pixel_stream_receiver;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] image_width, image_height;
  logic        valid_in, sof, last_x, ready_out, wr_valid, wr_ready;
  logic [7:0]  r, g, b;
  logic [25:0] wr_addr;
  logic [23:0] wr_data;
  logic        frame_done, sof_err, eol_err;
  logic [15:0] frame_count, drop_count;

  pixel_stream_receiver dut (
    .clk(clk), .reset_n(reset_n), .image_width(image_width), .image_height(image_height),
    .valid_in(valid_in), .r(r), .g(g), .b(b), .sof(sof), .last_x(last_x),
    .ready_out(ready_out), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .sof_err(sof_err), .eol_err(eol_err),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // staged stimulus
  bit s_rst_n = 0, s_valid = 0, s_sof = 0, s_last = 0;
  int s_w = 4, s_h = 2;
  int wr_mode = 0;
  bit tog = 0;
  // model
  bit armed = 0, m_wv, m_done, m_serr, m_eerr, m_act;
  int m_addr, m_data, m_fc, m_dc, m_x, m_y, m_w, m_h;
  int log_q[$], exp_q[$];
  int done_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_addr%0d", nm, i), 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  function automatic void model_reset();
    m_wv = 0; m_addr = 0; m_data = 0; m_done = 0; m_serr = 0; m_eerr = 0;
    m_fc = 0; m_dc = 0; m_act = 0; m_x = 0; m_y = 0; m_w = 0; m_h = 0;
  endfunction

  function automatic void push(input int a);
    m_wv = 1; m_addr = a; m_data = {r, g, b};
  endfunction

  function automatic void finish_frame();
    m_act = 0; m_done = 1; m_fc = (m_fc + 1) & 16'hFFFF;
  endfunction

  function automatic void drop_beat();
    if (m_dc < 65535) m_dc++;
  endfunction

  // Pixel-position view of the frame: address is always y*width + x.
  function automatic void model_accept();
    if (s_sof) begin
      if (m_act && (m_x != 0 || m_y != 0)) m_serr = 1;
      if (s_w != 0 && s_h != 0) begin
        m_w = s_w; m_h = s_h; push(0);
        if (m_w == 1 && m_h == 1) finish_frame();
        else begin m_act = 1; m_x = (m_w == 1) ? 0 : 1; m_y = (m_w == 1) ? 1 : 0; end
      end else begin
        m_act = 0; drop_beat();
      end
    end else if (!m_act) begin
      drop_beat();
    end else begin
      bit at_end = (m_x == m_w - 1);
      push(m_y * m_w + m_x);
      if (s_last != at_end) m_eerr = 1;
      if (s_last || at_end) begin
        if (m_y == m_h - 1) finish_frame();
        else begin m_x = 0; m_y++; end
      end else m_x++;
    end
  endfunction

  task automatic step(output bit xfer);
    bit rdy;
    @(negedge clk);
    if (armed) begin
      chk("wr_valid", 64'(wr_valid), 64'(m_wv));
      if (m_wv) begin
        chk("wr_addr", 64'(wr_addr), 64'(m_addr));
        chk("wr_data", 64'(wr_data), 64'(m_data));
      end
      chk("frame_done", 64'(frame_done), 64'(m_done));
      chk("sof_err", 64'(sof_err), 64'(m_serr));
      chk("eol_err", 64'(eol_err), 64'(m_eerr));
      chk("frame_count", 64'(frame_count), 64'(m_fc));
      chk("drop_count", 64'(drop_count), 64'(m_dc));
    end
    if (frame_done === 1'b1) done_seen++;
    reset_n = s_rst_n; valid_in = s_valid; sof = s_sof; last_x = s_last;
    image_width = 13'(s_w); image_height = 13'(s_h);
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    tog = ~tog;
    wr_ready = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? tog : 1'($urandom);
    #1;
    rdy = !m_wv || wr_ready;
    if (armed) chk("ready_out", 64'(ready_out), 64'(rdy));
    xfer = s_valid && rdy && s_rst_n;
    if (!s_rst_n) begin
      model_reset(); armed = 1;
      return;
    end
    if (m_wv && wr_ready) begin log_q.push_back(m_addr); m_wv = 0; end
    m_done = 0;
    if (xfer) model_accept();
  endtask

  task automatic idle(input int n);
    bit t;
    s_valid = 0; s_sof = 0; s_last = 0;
    repeat (n) step(t);
  endtask

  task automatic pix(input bit sf, input bit lx);
    bit t = 0;
    int n = 0;
    s_valid = 1; s_sof = sf; s_last = lx;
    while (!t && n < 50) begin step(t); n++; end
    if (!t) begin n_chk++; n_fail++; $display("FAIL beat_timeout: got no transfer expected transfer"); end
    s_valid = 0; s_sof = 0; s_last = 0;
  endtask

  task automatic frame(input int w, input int h);
    s_w = w; s_h = h;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) pix(xx == 0 && yy == 0, xx == w - 1);
  endtask

  task automatic do_reset();
    bit t;
    s_rst_n = 0; s_valid = 0; step(t); s_rst_n = 1;
  endtask

  task automatic seq_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0; valid_in = 0; sof = 0; last_x = 0; wr_ready = 1;
    r = 0; g = 0; b = 0; image_width = 4; image_height = 2;
    do_reset(); idle(1);
    chk("rst_ready", 64'(ready_out), 1);
    chk("rst_wr_valid", 64'(wr_valid), 0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    chk("rst_wr_data", 64'(wr_data), 0);
    chk("rst_frame_count", 64'(frame_count), 0);
    chk("rst_drop_count", 64'(drop_count), 0);

    // 4x2 clean frame
    log_q.delete(); done_seen = 0;
    frame(4, 2); idle(3);
    seq_exp(8); chk_log("t1");
    chk("t1_done_pulses", 64'(done_seen), 1);
    chk("t1_frame_count", 64'(frame_count), 1);
    chk("t1_eol_err", 64'(eol_err), 0);

    // same frame with toggling write ready
    wr_mode = 1; log_q.delete();
    frame(4, 2); idle(4);
    seq_exp(8); chk_log("t2");
    chk("t2_frame_count", 64'(frame_count), 2);
    wr_mode = 0;

    // drops before a 2x2 frame
    do_reset(); log_q.delete();
    s_w = 2; s_h = 2;
    pix(0, 0); pix(0, 1); pix(0, 0);
    frame(2, 2); idle(3);
    chk("t3_drop_count", 64'(drop_count), 3);
    seq_exp(4); chk_log("t3");

    // early last_x on line 0
    do_reset(); log_q.delete();
    s_w = 4; s_h = 2;
    pix(1, 0); pix(0, 1);
    pix(0, 0); pix(0, 0); pix(0, 0); pix(0, 1); idle(3);
    exp_q = '{0, 1, 4, 5, 6, 7}; chk_log("t4");
    chk("t4_eol_err", 64'(eol_err), 1);
    chk("t4_frame_count", 64'(frame_count), 1);

    // sof mid-frame at (2,1)
    do_reset(); log_q.delete();
    s_w = 4; s_h = 2;
    pix(1, 0); pix(0, 0); pix(0, 0); pix(0, 1); pix(0, 0); pix(0, 0);
    pix(1, 0); idle(2);
    chk("t5_sof_err", 64'(sof_err), 1);
    chk("t5_count_mid", 64'(frame_count), 0);
    pix(0, 0); pix(0, 0); pix(0, 1); pix(0, 0); pix(0, 0); pix(0, 0); pix(0, 1); idle(3);
    exp_q = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 6, 7}; chk_log("t5");
    chk("t5_frame_count", 64'(frame_count), 1);

    // reset mid-frame
    do_reset(); s_w = 4; s_h = 2;
    pix(1, 0); pix(0, 0); pix(0, 0);
    do_reset(); idle(1);
    chk("t6_wr_valid", 64'(wr_valid), 0);
    chk("t6_wr_addr", 64'(wr_addr), 0);
    chk("t6_wr_data", 64'(wr_data), 0);
    chk("t6_frame_count", 64'(frame_count), 0);
    log_q.delete();
    frame(2, 2); idle(3);
    seq_exp(4); chk_log("t6");
    chk("t6_frame_count_end", 64'(frame_count), 1);

    // randomized frames with framing faults, stalls, drops and resets
    wr_mode = 2;
    for (int f = 0; f < 60; f++) begin
      int w = $urandom_range(1, 4), h = $urandom_range(1, 4);
      if ($urandom_range(0, 11) == 0) w = 0;
      if ($urandom_range(0, 19) == 0) do_reset();
      if ($urandom_range(0, 4) == 0) pix(0, $urandom_range(0, 1));
      s_w = w; s_h = h;
      for (int yy = 0; yy < (h > 0 ? h : 1); yy++)
        for (int xx = 0; xx < (w > 0 ? w : 1); xx++) begin
          bit sf = (xx == 0 && yy == 0) || ($urandom_range(0, 39) == 0);
          bit lx = (xx == w - 1) ^ ($urandom_range(0, 14) == 0);
          idle($urandom_range(0, 2));
          pix(sf, lx);
        end
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_stream_receiver.md
# pixel_stream_receiver

Consumer end of the ray-tracer video pixel stream (valid/ready, r/g/b, sof, last_x). It accepts pixels from the RayTracingUnit output side and checks framing against the configured image size. Each accepted pixel becomes a linear-addressed write on a frame-buffer write port. It also reports framing errors, dropped beats and completed frames.

## Interface
Parameters:
- ADDR_W, 26, frame-buffer word address width (13 + 13)
- CNT_W, 16, width of frame/drop counters

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- image_width  in  13  pixels per line, sampled on frame start
- image_height  in  13  lines per frame, sampled on frame start
- valid_in  in  1  pixel beat valid
- r, g, b  in  8 each  pixel colour
- sof  in  1  start of frame, marks pixel (0,0)
- last_x  in  1  last pixel of a line
- ready_out  out  1  receiver can accept a beat
- wr_valid  out  1  frame-buffer write pending
- wr_ready  in  1  frame-buffer accepts the write
- wr_addr  out  ADDR_W  y*width + x
- wr_data  out  24  {r,g,b}
- frame_done  out  1  one-cycle pulse, frame completed
- sof_err  out  1  sticky: sof arrived mid-frame
- eol_err  out  1  sticky: last_x misplaced or missing
- frame_count  out  CNT_W  completed frames, wraps
- drop_count  out  CNT_W  beats discarded while idle, saturates

## Operation
- A transfer occurs when valid_in && ready_out.
- ready_out = !wr_valid || wr_ready in all states. There is a single output register with pass-through backpressure.
- FSM states:
  - IDLE:
    - A transfer with sof and nonzero width and height latches width/height, writes the pixel to addr 0, sets x=1 (or x=0, y=1 when width==1), and moves to ACTIVE.
    - Any other transfer, including sof with a zero dimension, is discarded and drop_count increments.
  - ACTIVE: each transfer writes at the current address, then advances x and addr.
    - End of line is x==width-1. At end of line: x←0, y←y+1.
    - End of line on the final line (y==height-1) ends the frame. The FSM returns to IDLE, frame_count increments and frame_done pulses.
- Framing rules in ACTIVE:
  - sof with (x,y)≠(0,0): set sof_err. The beat restarts the frame as pixel (0,0), re-latches the dimensions, writes to addr 0, and no frame_done is issued.
  - last_x with x<width-1: set eol_err and force end of line. addr is realigned to (y+1)*width.
  - x==width-1 without last_x: set eol_err. The line still ends normally.
  - sof and last_x on the same beat are legal when width==1.
- Address arithmetic:
  - addr is an incremental counter, not a multiplier.
  - Line-start address is held in a separate register (line_base + width) and is used for early-last_x realignment.
  - All values are unsigned and never exceed width*height-1.
- sof_err and eol_err stay set until reset.

## Timing
- Reset values: ready_out=1, wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, both error flags=0, both counters=0, FSM=IDLE.
- Latency: an accepted beat appears on wr_valid/wr_addr/wr_data on the next cycle. It holds stable until wr_valid && wr_ready.
- Throughput is 1 pixel/cycle when wr_ready is held high.
- frame_done asserts in the cycle after the final pixel transfer, coincident with that pixel's wr_valid. It lasts exactly one cycle.
- If reset_n is low mid-frame, the pending write is abandoned and all state returns to reset values the next cycle.
- wr_ready low while wr_valid=1 stalls ready_out low in the same cycle (combinational path).

## Structure
- Package pixel_rx_pkg:
  - state enum {IDLE, ACTIVE}
  - DIM_W=13, PIX_W=24
  - pixel_t packed struct {r,g,b}
- Sub-module pixel_out_stage: one-entry valid/ready register holding addr and data. It generates ready_out and is reusable for other stream sinks.
- The top-level module holds the FSM, x/y/addr/line_base counters, error flags and status counters.

## Test plan
- 4x2 frame, wr_ready=1, correct sof/last_x: addresses 0..7 in order, one frame_done pulse, frame_count=1, no errors.
- Same frame with wr_ready toggling 1-0-1-0: no lost or duplicated writes, and data is held stable while stalled.
- 3 beats without sof before a 2x2 frame: drop_count=3, frame writes addrs 0..3.
- 4x2 frame with last_x at x=1 on line 0: eol_err=1, the next beat writes addr 4, frame completes.
- sof at pixel (2,1) of a 4x2 frame: sof_err=1, that beat writes addr 0, frame_count is unchanged until the restarted frame ends.
- Reset asserted after 3 pixels, then a full 2x2 frame: all outputs return to reset values, the new frame writes 0..3, frame_count=1.
